// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble), optional BCD2BIN_FAST_EN
module bcd2bin_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   P,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
`ifdef BCD2BIN_FAST_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [2*W-1:0]    z_q;
    logic [2*W-1:0]    z_one;
    logic [2*W-1:0]    z_next;
    logic [CW-1:0]     cnt_q;
    logic              err_q;
    logic              bad_digit;

    // One reverse double-dabble step: shift right, then pull every BCD field
    // that landed at 8 or more back down by 3 (fields corrected in parallel).
    function automatic logic [2*W-1:0] dd_step(input logic [2*W-1:0] z);
        logic [2*W-1:0] s;
        s = z >> 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[W+4*k +: 4] >= 4'd8) begin
                s[W+4*k +: 4] = s[W+4*k +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    // Per-edge datapath update: one step, or two chained steps in the fast build.
    always_comb begin
        z_one = dd_step(z_q);
`ifdef BCD2BIN_FAST_EN
        z_next = dd_step(z_one);
`else
        z_next = z_one;
`endif
    end

    // Flag any input nibble outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (B[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, step counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            P     <= '0;
            err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        z_q   <= {B, {W{1'b0}}};
                        err_q <= bad_digit;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    z_q   <= z_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Malformed input still runs full length but reports zero.
                        P   <= err_q ? '0 : z_next[W-1:0];
                        err <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - self-checking bench for bcd2bin_seq
module tb_bcd2bin_seq;

`ifdef BCD2BIN_FAST_EN
    localparam int LAT  = 8;
    localparam int LAT2 = 4;
`else
    localparam int LAT  = 16;
    localparam int LAT2 = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic        err;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  B2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  P2;
    logic        err2;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bcd2bin_seq #(.DIGITS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .err(err)
    );

    bcd2bin_seq #(.DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .B(B2),
        .out_valid(out_valid2), .out_ready(out_ready2), .P(P2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: positional decimal value; any nibble over 9 flags an error.
    task automatic bcd_ref(input logic [15:0] b, output logic [15:0] v, output logic e);
        int acc;
        int mul;
        int d;
        acc = 0;
        mul = 1;
        e   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = int'(b[4*k +: 4]);
            if (d > 9) e = 1'b1;
            acc = acc + d * mul;
            mul = mul * 10;
        end
        v = e ? 16'h0000 : acc[15:0];
    endtask

    int          mst = 0;
    int          mleft = 0;
    logic [15:0] mp = '0;
    logic [15:0] mval = '0;
    logic        merr = 1'b0;
    logic        merr_n = 1'b0;

    // Transaction-level model of the 16-bit instance.
    always @(posedge clk) begin
        if (!rst_n) begin
            mst  = 0;
            mp   = '0;
            merr = 1'b0;
        end else begin
            case (mst)
                0: if (in_valid) begin
                    bcd_ref(B, mval, merr_n);
                    mleft = LAT;
                    mst   = 1;
                end
                1: begin
                    mleft--;
                    if (mleft == 0) begin
                        mst  = 2;
                        mp   = mval;
                        merr = merr_n;
                    end
                end
                default: if (out_ready) mst = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, (mst == 0));
            check("out_valid", out_valid, (mst == 2));
            check("P", P, mp);
            check("err", err, merr);
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic run_one(input logic [15:0] b, input logic [15:0] exp_p, input logic exp_e);
        int k;
        wait_ready();
        in_valid = 1'b1;
        B        = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        B        = 16'hFFFF;
        check("in_ready_run", in_ready, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, LAT);
        check("P_lit", P, exp_p);
        check("err_lit", err, exp_e);
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        B          = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        B2         = '0;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_P", P, 0);
        check("rst_err", err, 0);

        run_one(16'h9999, 16'h270F, 1'b0);
        run_one(16'h1234, 16'h04D2, 1'b0);
        run_one(16'h0000, 16'h0000, 1'b0);
        run_one(16'h0001, 16'h0001, 1'b0);
        run_one(16'h12A4, 16'h0000, 1'b1);
        @(posedge clk); #1;

        out_ready = 1'b0;
        run_one(16'h0512, 16'h0200, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_P", P, 16'h0200);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("handoff_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);

        in_valid = 1'b1;
        B        = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_P", P, 0);
        check("abort_err", err, 0);
        run_one(16'h0042, 16'h002A, 1'b0);

        in_valid2 = 1'b1;
        B2        = 8'h99;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        k = 0;
        while (!out_valid2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("d2_latency", k, LAT2);
        check("d2_P", P2, 8'h63);
        check("d2_err", err2, 0);
        check("d2_in_ready", in_ready2, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
